// File: rtl/sig_rom_prefetch.sv
// Signal-ROM prefetcher: streams a run of ROM words into a show-ahead FIFO.
// Optional abort input enabled by defining SIG_PREFETCH_ABORT_EN.
module sig_rom_prefetch #(
  parameter int ROM_SIG_WIDTH   = 100,
  parameter int SIG_ADDRS_WIDTH = 10,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       general_rst_i,
  input  logic                       start_i,
  input  logic [SIG_ADDRS_WIDTH-1:0] base_addrs_i,
  input  logic [SIG_ADDRS_WIDTH-1:0] num_words_i,
  output logic                       rd_rom_signals_ld_o,
  output logic [SIG_ADDRS_WIDTH-1:0] addrs_rom_signal_o,
  input  logic [ROM_SIG_WIDTH-1:0]   rom_signals_data_i,
  output logic [ROM_SIG_WIDTH-1:0]   sig_data_o,
  output logic                       sig_valid_o,
  input  logic                       sig_ready_i,
  output logic                       busy_o,
  output logic                       done_o
`ifdef SIG_PREFETCH_ABORT_EN
  ,
  input  logic                       abort_i
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = SIG_ADDRS_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [SW-1:0]            r_addr;
  logic [SW-1:0]            r_remain;
  logic [SW-1:0]            r_pending;
  logic                     r_inflight;
  logic                     r_done;
  logic [ROM_SIG_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wptr;
  logic [AW-1:0]            r_rptr;
  logic [CW-1:0]            r_count;

  logic                     w_abort;
  logic                     w_start;
  logic                     w_start_run;
  logic                     w_start_empty;
  logic [CW:0]              w_occ;
  logic                     w_rd;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_last_pop;

`ifdef SIG_PREFETCH_ABORT_EN
  assign w_abort = abort_i & (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_start       = start_i & (r_state == S_IDLE);
  assign w_start_run   = w_start & (num_words_i != '0);
  assign w_start_empty = w_start & (num_words_i == '0);

  // Credit: buffered words plus the outstanding read must leave room.
  assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};

  assign w_rd = (r_state == S_FETCH) & (r_remain != '0) &
                (w_occ < (CW + 1)'(FIFO_DEPTH)) & ~w_abort;

  assign w_push     = r_inflight;
  assign w_pop      = (r_count != '0) & sig_ready_i;
  assign w_last_pop = w_pop & (r_state == S_DRAIN) &
                      (r_pending == SW'(1));

  assign rd_rom_signals_ld_o = w_rd;
  assign addrs_rom_signal_o  = r_addr;
  assign sig_valid_o         = (r_count != '0);
  assign sig_data_o          = sig_valid_o ? r_mem[r_rptr] : '0;
  assign busy_o              = (r_state != S_IDLE);
  assign done_o              = r_done;

  // State register.
  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_run) w_next = S_FETCH;
      S_FETCH: if (w_rd && r_remain == SW'(1)) w_next = S_DRAIN;
      S_DRAIN: if (w_last_pop) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Run counters, address generator, read tracking and done pulse.
  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_pending  <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= w_start_empty | (w_last_pop & ~w_abort);
      r_inflight <= w_rd;
      if (w_start) begin
        r_addr    <= base_addrs_i;
        r_remain  <= num_words_i;
        r_pending <= num_words_i;
      end else begin
        if (w_rd) begin
          r_addr   <= r_addr + SW'(1);
          r_remain <= r_remain - SW'(1);
        end
        if (w_pop) r_pending <= r_pending - SW'(1);
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; returned ROM data lands at the tail.
  always_ff @(posedge clk_i) begin
    if (w_push && !w_abort) r_mem[r_wptr] <= rom_signals_data_i;
  end

endmodule

// File: tb/tb_sig_rom_prefetch.sv
// Self-checking bench for sig_rom_prefetch.
// Scoreboard queues hold expected read addresses and output words.
module tb_sig_rom_prefetch;

  localparam int DW = 100;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] num = '0;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready = 1'b1;
  logic          busy;
  logic          done;
`ifdef SIG_PREFETCH_ABORT_EN
  logic          abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  always #5 clk = ~clk;

  sig_rom_prefetch dut (
    .clk_i               (clk),
    .general_rst_i       (rst),
    .start_i             (start),
    .base_addrs_i        (base),
    .num_words_i         (num),
    .rd_rom_signals_ld_o (rd),
    .addrs_rom_signal_o  (addr),
    .rom_signals_data_i  (rom_q),
    .sig_data_o          (data),
    .sig_valid_o         (valid),
    .sig_ready_i         (ready),
    .busy_o              (busy),
    .done_o              (done)
`ifdef SIG_PREFETCH_ABORT_EN
    ,
    .abort_i             (abort)
`endif
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, ~a, {8{a}}};
  endfunction

  // ROM model with one-cycle read latency.
  always @(posedge clk) begin
    if (rd) rom_q <= rom_word(addr);
  end

  // Monitor: reads and transfers checked against scoreboard.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (done) done_cnt++;
    if (rd) begin
      rd_cnt++;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL read_addr: unexpected read at %h", addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (addr !== ea) begin
          errors++;
          $display("FAIL read_addr: got %h want %h", addr, ea);
        end
      end
    end
    if (valid && ready) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL out_data: unexpected word %h", data);
      end else begin
        ed = exp_data_q.pop_front();
        if (data !== ed) begin
          errors++;
          $display("FAIL out_data: got %h want %h", data, ed);
        end
      end
    end
  end

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] n);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    num   = n;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(rom_word(a));
      a = a + 10'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done want done within %0d", budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({rd, addr, data, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got rd=%b a=%h v=%b b=%b d=%b want 0",
               rd, addr, valid, busy, done);
    end
    #3 rst = 1'b0;
  endtask

  task automatic test_basic;
    int d0 = done_cnt;
    int r0 = rd_cnt;
    start_run(10'h010, 10'd5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd !== 1'b1) begin
        errors++;
        $display("FAIL basic_rd%0d: got %b want 1", i, rd);
      end
      if (i < 2) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_latency%0d: got valid=%b want 0", i, valid);
        end
      end
      if (i == 2) begin
        checks++;
        if (valid !== 1'b1 || data !== rom_word(10'h010)) begin
          errors++;
          $display("FAIL basic_first: got v=%b %h want 1 %h",
                   valid, data, rom_word(10'h010));
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: got rd=%b busy=%b want 0 1", rd, busy);
    end
    wait_done(20);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall: got %b want 0", busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1 || rd_cnt - r0 != 5 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL basic_counts: got done=%0d rd=%0d left=%0d want 1 5 0",
               done_cnt - d0, rd_cnt - r0, exp_data_q.size());
    end
  endtask

  task automatic test_backpressure;
    int r0 = rd_cnt;
    ready = 1'b0;
    start_run(10'h040, 10'd8);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i >= 3) begin
        checks++;
        if (valid !== 1'b1 || data !== rom_word(10'h040)) begin
          errors++;
          $display("FAIL bp_stable%0d: got v=%b %h want 1 %h",
                   i, valid, data, rom_word(10'h040));
        end
      end
    end
    checks++;
    if (rd_cnt - r0 != 4 || rd !== 1'b0) begin
      errors++;
      $display("FAIL bp_reads: got %0d rd=%b want 4 0", rd_cnt - r0, rd);
    end
    ready = 1'b1;
    wait_done(40);
    checks++;
    if (rd_cnt - r0 != 8 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL bp_complete: got rd=%0d left=%0d want 8 0",
               rd_cnt - r0, exp_data_q.size());
    end
  endtask

  task automatic test_wrap;
    int r0 = rd_cnt;
    start_run(10'h3FE, 10'd4);
    wait_done(20);
    checks++;
    if (rd_cnt - r0 != 4 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: got rd=%0d left=%0d want 4 0",
               rd_cnt - r0, exp_data_q.size());
    end
  endtask

  task automatic test_empty;
    int r0 = rd_cnt;
    start_run(10'h123, 10'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rd !== 1'b0) begin
      errors++;
      $display("FAIL empty_pulse: got d=%b b=%b rd=%b want 1 0 0",
               done, busy, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_cnt != r0) begin
      errors++;
      $display("FAIL empty_after: got d=%b b=%b rd=%0d want 0 0 0",
               done, busy, rd_cnt - r0);
    end
  endtask

  task automatic test_start_busy;
    int r0 = rd_cnt;
    int d0 = done_cnt;
    start_run(10'h080, 10'd6);
    @(posedge clk); #1;
    start = 1'b1;
    base  = 10'h100;
    num   = 10'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt - r0 != 6 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: got rd=%0d done=%0d busy=%b want 6 1 0",
               rd_cnt - r0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid;
    ready = 1'b0;
    start_run(10'h050, 10'd8);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (rd !== 1'b1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got rd=%b v=%b want 1 1", rd, valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rd, addr, data, valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL rstmid_outs: got rd=%b a=%h v=%b b=%b want 0",
               rd, addr, valid, busy);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    #13 rst = 1'b0;
    ready = 1'b1;
    start_run(10'h200, 10'd3);
    wait_done(20);
    checks++;
    if (exp_data_q.size() != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_new: got left=%0d v=%b want 0 0",
               exp_data_q.size(), valid);
    end
  endtask

`ifdef SIG_PREFETCH_ABORT_EN
  task automatic test_abort;
    int d0 = done_cnt;
    ready = 1'b0;
    start_run(10'h300, 10'd8);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: got v=%b b=%b d=%b want 0 0 0",
               valid, busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_done: got %0d want 0", done_cnt - d0);
    end
    ready = 1'b1;
    start_run(10'h020, 10'd3);
    wait_done(20);
    checks++;
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL abort_after: got left=%0d want 0", exp_data_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_empty();
    test_start_busy();
    test_reset_mid();
`ifdef SIG_PREFETCH_ABORT_EN
    test_abort();
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
